completion_arbiter: RTL and testbench
=====================================

// Module: completion_arbiter
// PURPOSE
//  Shares the single ROB completion port and the PRF wakeup port among the ALU, branch and LSU FUs.
//  Each FU pushes a completion record into its own small queue. A round-robin scheduler grants one
//  record per cycle and drives the registered ROB-complete and preg-wakeup outputs.
//  Sits between FU writeback and the dispatch/ROB/PRF ready logic.
// PARAMETERS
//  N_REQ    3   number of requesting FUs (index 0=ALU, 1=BR, 2=LSU)
//  DEPTH    2   entries per requester queue (power of 2, >=2)
//  PREG_W   7   physical register tag width
//  TAG_W    5   ROB tag width
// PORTS
//  clk              in   1              clock
//  reset            in   1              synchronous, active-low reset (asserted when 0)
//  req_valid        in   N_REQ          FU i presents a completion record
//  req_data         in   N_REQ x cmpl_req_t  {preg, has_dest, rob_tag} per FU
//  req_ready        out  N_REQ          queue i can accept this cycle
//  mispredict       in   1              flush request from branch resolution
//  cmpl_valid       out  1              registered: one completion granted
//  cmpl_rob_tag     out  TAG_W          ROB tag of the granted record
//  wakeup_valid     out  1              registered: granted record writes a preg
//  wakeup_preg      out  PREG_W         preg to mark ready in PRF/RS
//  grant_id         out  2              registered: index of the granted requester (debug/perf)
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - all queues empty; rr pointer=0.
//   - cmpl_valid=0, wakeup_valid=0, cmpl_rob_tag=0, wakeup_preg=0, grant_id=0.
//  Handshake:
//   - req_ready[i] = !full[i] && !mispredict.
//   - Push on req_valid[i] && req_ready[i].
//   - req_valid while !req_ready: record is not accepted. The FU holds it stable.
//  Queue: per-requester circular FIFO with wrapping rd/wr pointers and a count of 0..DEPTH.
//   - Simultaneous push and pop on a full queue is legal: count is unchanged.
//   - Pop on an empty queue never occurs.
//  Arbitration (every cycle, combinational select, registered output):
//   - Eligible = queues with count>0, evaluated on pre-push state.
//   - A record pushed at cycle t is grantable at t+1 at the earliest.
//   - Grant the first eligible index starting at rr_ptr, searching upward mod N_REQ.
//   - Pop the granted queue. Set rr_ptr = (granted+1) mod N_REQ.
//   - With no eligible queue, rr_ptr is unchanged.
//  Outputs, registered at the grant edge:
//   - cmpl_valid=1, cmpl_rob_tag=head.rob_tag, grant_id=granted.
//   - wakeup_valid = head.has_dest && head.preg!=0. wakeup_preg = head.preg when wakeup_valid, else 0.
//   - With no grant: cmpl_valid=0, wakeup_valid=0. Tag/preg/grant_id hold their last values.
//  Latency: push at edge t, empty queues, no contention -> cmpl_valid high in cycle after edge t+1.
//  Throughput: 1 completion/cycle total. Worst-case wait for a queued head is N_REQ-1 grants.
//  Mispredict (level, sampled at posedge):
//   - All queues are cleared (count=0, pointers=0).
//   - No grant that cycle; outputs cmpl_valid=0, wakeup_valid=0 next cycle.
//   - Same-cycle pushes are dropped (req_ready=0).
//   - rr_ptr is unchanged.
//  Reset has priority over mispredict. Reset asserted mid-operation discards all queued records.
// STRUCTURE
//  types_pkg additions:
//   - typedef struct packed {logic [6:0] preg; logic has_dest; logic [4:0] rob_tag;} cmpl_req_t.
//   - localparam FU_ALU=0, FU_BR=1, FU_LSU=2.
//  Sub-module cmpl_fifo #(T, DEPTH):
//   - ports clk, reset, flush, push, din, pop, dout, full, empty.
//   - Instantiated N_REQ times via generate.
//  Round-robin select and output registers live in completion_arbiter itself.
// TESTING
//  1 Reset held 0 for 2 cycles while req_valid=3'b111 -> all outputs 0, req_ready=000.
//    Release -> req_ready=111.
//  2 Single push ALU {preg=7'd12,has_dest=1,tag=5'd3} at edge t
//    -> after edge t+1: cmpl_valid=1, cmpl_rob_tag=3, wakeup_valid=1, wakeup_preg=12, grant_id=0.
//  3 All three FUs push once at the same edge, rr=0 -> grants on 3 consecutive cycles, grant_id 0,1,2.
//    Then cmpl_valid=0.
//  4 Branch record with has_dest=0, tag=5'd7 -> cmpl_valid=1, cmpl_rob_tag=7, wakeup_valid=0, wakeup_preg=0.
//    Record with has_dest=1, preg=0 -> wakeup_valid=0.
//  5 LSU pushes every cycle while ALU and BR also push -> LSU queue fills (DEPTH=2), req_ready[2]=0.
//    LSU granted every 3rd cycle. No record lost or duplicated; scoreboard order per FU preserved.
//  6 Queues hold 2,1,2 records; assert mispredict 1 cycle with req_valid=111
//    -> next cycle cmpl_valid=0, all queues empty, nothing from the flushed set ever emitted.

Source files
------------

// File: rtl/completion_arbiter_pkg.sv
// Shared types and sizing for the FU completion arbiter: record layout, FU indices
// and the round-robin index helper.
package completion_arbiter_pkg;

    localparam int N_REQ  = 3;
    localparam int DEPTH  = 2;
    localparam int PREG_W = 7;
    localparam int TAG_W  = 5;
    localparam int GID_W  = 2;

    localparam int FU_ALU = 0;
    localparam int FU_BR  = 1;
    localparam int FU_LSU = 2;

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic              has_dest;
        logic [TAG_W-1:0]  rob_tag;
    } cmpl_req_t;

    // Requester index `off` positions above `base`, wrapping at N_REQ (both inputs < N_REQ).
    function automatic logic [GID_W-1:0] rr_index(input logic [GID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return GID_W'(s);
    endfunction

endpackage

// File: rtl/completion_arbiter_if.sv
// FU-side completion requests and arbiter-side ROB/PRF outputs bundled as one interface.
interface completion_arbiter_if;
    import completion_arbiter_pkg::*;

    // req_valid[i]/req_ready[i]: a record transfers on a clock edge where both are high;
    // while valid is high and ready is low the FU holds req_data[i] stable.
    logic [N_REQ-1:0]            req_valid;
    cmpl_req_t [N_REQ-1:0]       req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        mispredict;
    logic                        cmpl_valid;
    logic [TAG_W-1:0]            cmpl_rob_tag;
    logic                        wakeup_valid;
    logic [PREG_W-1:0]           wakeup_preg;
    logic [GID_W-1:0]            grant_id;
    logic [GID_W-1:0]            rr_ptr;

    modport master (
        output req_valid, req_data, mispredict,
        input  req_ready, cmpl_valid, cmpl_rob_tag, wakeup_valid, wakeup_preg, grant_id, rr_ptr
    );

    modport slave (
        input  req_valid, req_data, mispredict,
        output req_ready, cmpl_valid, cmpl_rob_tag, wakeup_valid, wakeup_preg, grant_id, rr_ptr
    );

endinterface

// File: rtl/completion_arbiter_cmpl_fifo.sv
// Small circular FIFO holding one FU's pending completion records; flush empties it in one cycle.
module cmpl_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/completion_arbiter.sv
// Round-robin sharing of the ROB completion and PRF wakeup ports among the ALU, BR and LSU
// queues; one registered grant per cycle, mispredict flushes every queue.
module completion_arbiter
    import completion_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    completion_arbiter_if.slave  bus
);

    logic [N_REQ-1:0] fifo_full, fifo_empty, push, pop, ready;
    cmpl_req_t        head [N_REQ];
    cmpl_req_t        gnt_rec;

    logic             grant_vld;
    logic [GID_W-1:0] grant_idx;
    logic             wake;

    logic             cmpl_valid_q, cmpl_valid_d;
    logic [TAG_W-1:0] cmpl_rob_tag_q, cmpl_rob_tag_d;
    logic             wakeup_valid_q, wakeup_valid_d;
    logic [PREG_W-1:0] wakeup_preg_q, wakeup_preg_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_q
            assign ready[i] = reset && !fifo_full[i] && !bus.mispredict;
            assign push[i]  = bus.req_valid[i] && ready[i];
            assign pop[i]   = grant_vld && (grant_idx == GID_W'(i));

            cmpl_fifo #(.T(cmpl_req_t), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .flush (bus.mispredict),
                .push  (push[i]),
                .din   (bus.req_data[i]),
                .pop   (pop[i]),
                .dout  (head[i]),
                .full  (fifo_full[i]),
                .empty (fifo_empty[i])
            );
        end
    endgenerate

    // Eligibility uses pre-push occupancy, so a record is never granted on its push edge.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        if (!bus.mispredict) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_vld && !fifo_empty[rr_index(rr_ptr_q, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_index(rr_ptr_q, k);
                end
            end
        end
    end

    assign gnt_rec = head[grant_idx];
    assign wake    = gnt_rec.has_dest && (gnt_rec.preg != '0);

    always_comb begin
        cmpl_valid_d   = grant_vld;
        wakeup_valid_d = 1'b0;
        cmpl_rob_tag_d = cmpl_rob_tag_q;
        wakeup_preg_d  = wakeup_preg_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        if (grant_vld) begin
            cmpl_rob_tag_d = gnt_rec.rob_tag;
            grant_id_d     = grant_idx;
            wakeup_valid_d = wake;
            wakeup_preg_d  = wake ? gnt_rec.preg : '0;
            rr_ptr_d       = rr_index(grant_idx, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmpl_valid_q   <= 1'b0;
            cmpl_rob_tag_q <= '0;
            wakeup_valid_q <= 1'b0;
            wakeup_preg_q  <= '0;
            grant_id_q     <= '0;
            rr_ptr_q       <= '0;
        end else begin
            cmpl_valid_q   <= cmpl_valid_d;
            cmpl_rob_tag_q <= cmpl_rob_tag_d;
            wakeup_valid_q <= wakeup_valid_d;
            wakeup_preg_q  <= wakeup_preg_d;
            grant_id_q     <= grant_id_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.cmpl_valid   = cmpl_valid_q;
    assign bus.cmpl_rob_tag = cmpl_rob_tag_q;
    assign bus.wakeup_valid = wakeup_valid_q;
    assign bus.wakeup_preg  = wakeup_preg_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_completion_arbiter.sv
// Directed bench for completion_arbiter: hand-computed grant sequences plus a per-FU record scoreboard.
module tb_completion_arbiter;
    import completion_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    completion_arbiter_if bus ();

    completion_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmpl_req_t mk(input int preg, input logic hd, input int tag);
        cmpl_req_t r;
        r.preg     = PREG_W'(preg);
        r.has_dest = hd;
        r.rob_tag  = TAG_W'(tag);
        return r;
    endfunction

    function automatic cmpl_req_t mk_stream(input int fu, input int n);
        logic [31:0] nb;
        nb = 32'(n);
        return mk(40 + fu * 10 + n, nb[0], fu * 10 + n);
    endfunction

    task automatic expect_out(input string tag, input logic cv, input int rob, input logic wv,
                              input int wp, input int gid);
        chk({tag, "_cmpl_valid"},   32'(bus.cmpl_valid),   32'(cv));
        chk({tag, "_rob_tag"},      32'(bus.cmpl_rob_tag), 32'(rob));
        chk({tag, "_wakeup_valid"}, 32'(bus.wakeup_valid), 32'(wv));
        chk({tag, "_wakeup_preg"},  32'(bus.wakeup_preg),  32'(wp));
        chk({tag, "_grant_id"},     32'(bus.grant_id),     32'(gid));
    endtask

    // Scoreboard: per-FU expected queues, checked on every granted completion
    logic [$bits(cmpl_req_t)-1:0] exp_q0[$];
    logic [$bits(cmpl_req_t)-1:0] exp_q1[$];
    logic [$bits(cmpl_req_t)-1:0] exp_q2[$];

    always @(negedge clk) begin
        cmpl_req_t e;
        logic      have;
        logic      wv;
        if (bus.cmpl_valid === 1'b1) begin
            have = 1'b0;
            e    = '0;
            case (bus.grant_id)
                2'd0: if (exp_q0.size() > 0) begin e = cmpl_req_t'(exp_q0.pop_front()); have = 1'b1; end
                2'd1: if (exp_q1.size() > 0) begin e = cmpl_req_t'(exp_q1.pop_front()); have = 1'b1; end
                2'd2: if (exp_q2.size() > 0) begin e = cmpl_req_t'(exp_q2.pop_front()); have = 1'b1; end
                default: have = 1'b0;
            endcase
            chk("sb_record_expected", 32'(have), 32'd1);
            if (have) begin
                wv = e.has_dest && (e.preg != '0);
                chk("sb_rob_tag",      32'(bus.cmpl_rob_tag), 32'(e.rob_tag));
                chk("sb_wakeup_valid", 32'(bus.wakeup_valid), 32'(wv));
                chk("sb_wakeup_preg",  32'(bus.wakeup_preg),  wv ? 32'(e.preg) : 32'd0);
            end
        end
        if (!reset || bus.mispredict) begin
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
        end else begin
            if (bus.req_valid[0] && bus.req_ready[0]) exp_q0.push_back(bus.req_data[0]);
            if (bus.req_valid[1] && bus.req_ready[1]) exp_q1.push_back(bus.req_data[1]);
            if (bus.req_valid[2] && bus.req_ready[2]) exp_q2.push_back(bus.req_data[2]);
        end
    end

    // Directed sequence
    initial begin
        logic [N_REQ-1:0] acc;
        logic             lsu_full_seen;
        int               n [N_REQ];

        reset          = 1'b0;
        bus.mispredict = 1'b0;
        bus.req_valid  = 3'b111;
        bus.req_data[0] = mk(1, 1'b1, 31);
        bus.req_data[1] = mk(2, 1'b1, 30);
        bus.req_data[2] = mk(3, 1'b1, 29);

        // 1: reset held for two edges with requests pending
        tick();
        tick();
        expect_out("reset", 1'b0, 0, 1'b0, 0, 0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'b000);
        reset         = 1'b1;
        bus.req_valid = 3'b000;
        #1;
        chk("release_req_ready", 32'(bus.req_ready), 32'b111);

        // 2: single ALU push, two-edge latency
        bus.req_data[FU_ALU] = mk(12, 1'b1, 3);
        bus.req_valid        = 3'b001;
        tick();
        bus.req_valid = 3'b000;
        chk("latency_not_yet", 32'(bus.cmpl_valid), 32'd0);
        tick();
        expect_out("alu_single", 1'b1, 3, 1'b1, 12, 0);
        tick();
        expect_out("idle_hold", 1'b0, 3, 1'b0, 12, 0);

        // rr_ptr is 1 here; a lone LSU grant brings it back to 0
        bus.req_data[FU_LSU] = mk(5, 1'b1, 9);
        bus.req_valid        = 3'b100;
        tick();
        bus.req_valid = 3'b000;
        tick();
        expect_out("lsu_single", 1'b1, 9, 1'b1, 5, 2);
        tick();

        // 3: all three push together, rr=0 -> grants 0,1,2
        bus.req_data[0] = mk(20, 1'b1, 10);
        bus.req_data[1] = mk(21, 1'b1, 11);
        bus.req_data[2] = mk(22, 1'b1, 12);
        bus.req_valid   = 3'b111;
        tick();
        bus.req_valid = 3'b000;
        tick();
        expect_out("rr_first", 1'b1, 10, 1'b1, 20, 0);
        tick();
        expect_out("rr_second", 1'b1, 11, 1'b1, 21, 1);
        tick();
        expect_out("rr_third", 1'b1, 12, 1'b1, 22, 2);
        tick();
        chk("rr_done_cmpl_valid", 32'(bus.cmpl_valid), 32'd0);

        // 4: no-destination branch, then has_dest with preg 0
        bus.req_data[FU_BR] = mk(33, 1'b0, 7);
        bus.req_valid       = 3'b010;
        tick();
        bus.req_valid = 3'b000;
        tick();
        expect_out("br_nodest", 1'b1, 7, 1'b0, 0, 1);
        bus.req_data[FU_ALU] = mk(0, 1'b1, 8);
        bus.req_valid        = 3'b001;
        tick();
        bus.req_valid = 3'b000;
        tick();
        expect_out("preg_zero", 1'b1, 8, 1'b0, 0, 0);
        tick();

        // 5: every FU pushes every cycle; rr starts at 1
        lsu_full_seen = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            n[i] = 0;
            bus.req_data[i] = mk_stream(i, 0);
        end
        bus.req_valid = 3'b111;
        for (int k = 0; k <= 12; k++) begin
            acc = bus.req_valid & bus.req_ready;
            if (!bus.req_ready[FU_LSU]) lsu_full_seen = 1'b1;
            tick();
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) begin
                    n[i]++;
                    bus.req_data[i] = mk_stream(i, n[i]);
                end
            end
            if (k == 0) begin
                chk("stream_first_edge", 32'(bus.cmpl_valid), 32'd0);
            end else begin
                chk("stream_cmpl_valid", 32'(bus.cmpl_valid), 32'd1);
                chk("stream_grant_id",   32'(bus.grant_id),   32'(k % 3));
            end
        end
        bus.req_valid = 3'b000;
        chk("stream_lsu_backpressure", 32'(lsu_full_seen), 32'd1);
        for (int k = 0; k < 8; k++) tick();
        chk("stream_drained", 32'(bus.cmpl_valid), 32'd0);

        // 6: queues at 2,1,2 then mispredict with all requesters valid
        bus.req_data[FU_ALU] = mk(70, 1'b1, 1);
        bus.req_valid        = 3'b001;
        tick();
        bus.req_valid = 3'b000;
        tick();
        chk("flush_setup_grant", 32'(bus.grant_id), 32'd0);
        bus.req_data[0] = mk(50, 1'b1, 20);
        bus.req_data[1] = mk(51, 1'b1, 21);
        bus.req_data[2] = mk(52, 1'b1, 22);
        bus.req_valid   = 3'b111;
        tick();
        bus.req_data[0] = mk(53, 1'b1, 23);
        bus.req_data[1] = mk(54, 1'b1, 24);
        bus.req_data[2] = mk(55, 1'b1, 25);
        tick();
        expect_out("pre_flush", 1'b1, 21, 1'b1, 51, 1);
        bus.req_data[0] = mk(56, 1'b1, 26);
        bus.req_data[1] = mk(57, 1'b1, 27);
        bus.req_data[2] = mk(58, 1'b1, 28);
        bus.mispredict  = 1'b1;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'b000);
        tick();
        bus.mispredict = 1'b0;
        bus.req_valid  = 3'b000;
        chk("flush_cmpl_valid",   32'(bus.cmpl_valid),   32'd0);
        chk("flush_wakeup_valid", 32'(bus.wakeup_valid), 32'd0);
        tick();
        chk("flush_empty_1", 32'(bus.cmpl_valid), 32'd0);
        tick();
        chk("flush_empty_2", 32'(bus.cmpl_valid), 32'd0);

        // rr_ptr stayed at 2 across the flush; queues usable again
        bus.req_data[FU_LSU] = mk(60, 1'b1, 26);
        bus.req_valid        = 3'b100;
        tick();
        bus.req_valid = 3'b000;
        tick();
        expect_out("post_flush", 1'b1, 26, 1'b1, 60, 2);
        tick();
        tick();

        chk("sb_alu_left", 32'(exp_q0.size()), 32'd0);
        chk("sb_br_left",  32'(exp_q1.size()), 32'd0);
        chk("sb_lsu_left", 32'(exp_q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
